// File: rtl/player_motion_ctrl.sv
// Player motion controller: debounced one-hot buttons drive grid position and heading,
// with forward moves validated against the map through a req/ack lookup.
module player_motion_ctrl #(
    parameter int COORD_W     = 4,
    parameter int DB_CYCLES   = 1000000,
    parameter int ACK_TIMEOUT = 255,
    parameter int START_X     = 1,
    parameter int START_Y     = 1,
    parameter int START_DIR   = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rotate_n90_press,
    input  logic               forward_press,
    input  logic               rotate_90_press,
    output logic               map_req,
    output logic [COORD_W-1:0] map_x,
    output logic [COORD_W-1:0] map_y,
    input  logic               map_ack,
    input  logic               map_wall,
    output logic [COORD_W-1:0] pos_x,
    output logic [COORD_W-1:0] pos_y,
    output logic [1:0]         heading,
    output logic               moved,
    output logic               blocked,
    output logic               busy
);

    localparam int DB_W = $clog2(DB_CYCLES + 1);
    localparam int TO_W = $clog2(ACK_TIMEOUT + 1);

    localparam logic [DB_W-1:0]    DB_LAST   = DB_W'(DB_CYCLES - 1);
    localparam logic [DB_W-1:0]    DB_ONE    = DB_W'(1);
    localparam logic [DB_W-1:0]    DB_ZERO   = DB_W'(0);
    localparam logic [TO_W-1:0]    TO_LAST   = TO_W'(ACK_TIMEOUT - 1);
    localparam logic [TO_W-1:0]    TO_ONE    = TO_W'(1);
    localparam logic [TO_W-1:0]    TO_ZERO   = TO_W'(0);
    localparam logic [COORD_W-1:0] C_ZERO    = COORD_W'(0);
    localparam logic [COORD_W-1:0] C_ONE     = COORD_W'(1);
    localparam logic [COORD_W-1:0] C_MAX     = {COORD_W{1'b1}};
    localparam logic [COORD_W-1:0] C_START_X = COORD_W'(START_X);
    localparam logic [COORD_W-1:0] C_START_Y = COORD_W'(START_Y);
    localparam logic [1:0]         D_START   = 2'(START_DIR);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_QUERY = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Button index: 0 = rotate -90, 1 = forward, 2 = rotate +90
    logic [2:0]      raw_s;
    logic [2:0]      sync1_r;
    logic [2:0]      sync2_r;
    logic [2:0]      db_r;
    logic [2:0]      db_prev_r;
    logic [DB_W-1:0] db_cnt_r [3];
    logic [2:0]      rise_s;
    logic            evt_n90_s;
    logic            evt_fwd_s;
    logic            evt_p90_s;

    state_t state_r;
    state_t state_s;

    logic [COORD_W-1:0] pos_x_r, pos_x_s;
    logic [COORD_W-1:0] pos_y_r, pos_y_s;
    logic [1:0]         heading_r, heading_s;
    logic               map_req_r, map_req_s;
    logic [COORD_W-1:0] map_x_r, map_x_s;
    logic [COORD_W-1:0] map_y_r, map_y_s;
    logic               moved_r, moved_s;
    logic               blocked_r, blocked_s;
    logic               busy_r;
    logic [TO_W-1:0]    tmo_cnt_r, tmo_cnt_s;
    logic               tmo_hit_s;
    logic [COORD_W-1:0] tgt_x_s;
    logic [COORD_W-1:0] tgt_y_s;
    logic               oob_s;

    assign raw_s = {rotate_90_press, forward_press, rotate_n90_press};

    // Two-flop synchroniser for the raw button levels
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 3'b000;
            sync2_r <= 3'b000;
        end else begin
            sync1_r <= raw_s;
            sync2_r <= sync1_r;
        end
    end

    // Debounce: a level is accepted after DB_CYCLES consecutive differing samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_r      <= 3'b000;
            db_prev_r <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                db_cnt_r[i] <= DB_ZERO;
            end
        end else begin
            db_prev_r <= db_r;
            for (int i = 0; i < 3; i++) begin
                if (sync2_r[i] != db_r[i]) begin
                    if (db_cnt_r[i] == DB_LAST) begin
                        db_r[i]     <= sync2_r[i];
                        db_cnt_r[i] <= DB_ZERO;
                    end else begin
                        db_cnt_r[i] <= db_cnt_r[i] + DB_ONE;
                    end
                end else begin
                    db_cnt_r[i] <= DB_ZERO;
                end
            end
        end
    end

    // An edge only counts when the other two buttons are released
    assign rise_s    = db_r & ~db_prev_r;
    assign evt_n90_s = rise_s[0] & ~db_r[1] & ~db_r[2];
    assign evt_fwd_s = rise_s[1] & ~db_r[0] & ~db_r[2];
    assign evt_p90_s = rise_s[2] & ~db_r[0] & ~db_r[1];
    assign tmo_hit_s = (tmo_cnt_r == TO_LAST);

    // Target cell one step ahead; leaving the grid is refused rather than wrapped
    always_comb begin
        tgt_x_s = pos_x_r;
        tgt_y_s = pos_y_r;
        oob_s   = 1'b0;
        case (heading_r)
            2'd0: begin
                if (pos_y_r == C_ZERO) oob_s = 1'b1;
                else                   tgt_y_s = pos_y_r - C_ONE;
            end
            2'd1: begin
                if (pos_x_r == C_MAX) oob_s = 1'b1;
                else                  tgt_x_s = pos_x_r + C_ONE;
            end
            2'd2: begin
                if (pos_y_r == C_MAX) oob_s = 1'b1;
                else                  tgt_y_s = pos_y_r + C_ONE;
            end
            2'd3: begin
                if (pos_x_r == C_ZERO) oob_s = 1'b1;
                else                   tgt_x_s = pos_x_r - C_ONE;
            end
            default: oob_s = 1'b1;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= ST_IDLE;
        else        state_r <= state_s;
    end

    // FSM next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (evt_fwd_s && !oob_s) state_s = ST_QUERY;
                else                     state_s = ST_IDLE;
            end
            ST_QUERY: begin
                if (map_ack || tmo_hit_s) state_s = ST_DONE;
                else                      state_s = ST_QUERY;
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // FSM output logic: next values for the registered player state and map port
    always_comb begin
        pos_x_s   = pos_x_r;
        pos_y_s   = pos_y_r;
        heading_s = heading_r;
        map_req_s = map_req_r;
        map_x_s   = map_x_r;
        map_y_s   = map_y_r;
        moved_s   = 1'b0;
        blocked_s = 1'b0;
        tmo_cnt_s = tmo_cnt_r;
        case (state_r)
            ST_IDLE: begin
                tmo_cnt_s = TO_ZERO;
                if (evt_n90_s) begin
                    heading_s = heading_r - 2'd1;
                    moved_s   = 1'b1;
                end else if (evt_p90_s) begin
                    heading_s = heading_r + 2'd1;
                    moved_s   = 1'b1;
                end else if (evt_fwd_s) begin
                    if (oob_s) begin
                        blocked_s = 1'b1;
                    end else begin
                        map_req_s = 1'b1;
                        map_x_s   = tgt_x_s;
                        map_y_s   = tgt_y_s;
                    end
                end else begin
                    map_req_s = 1'b0;
                end
            end
            ST_QUERY: begin
                if (map_ack) begin
                    map_req_s = 1'b0;
                    if (map_wall) begin
                        blocked_s = 1'b1;
                    end else begin
                        pos_x_s = map_x_r;
                        pos_y_s = map_y_r;
                        moved_s = 1'b1;
                    end
                end else if (tmo_hit_s) begin
                    map_req_s = 1'b0;
                    blocked_s = 1'b1;
                end else begin
                    tmo_cnt_s = tmo_cnt_r + TO_ONE;
                end
            end
            ST_DONE: begin
                map_req_s = 1'b0;
                tmo_cnt_s = TO_ZERO;
            end
            default: begin
                map_req_s = 1'b0;
                tmo_cnt_s = TO_ZERO;
            end
        endcase
    end

    // Registered player state, map port and status pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_x_r   <= C_START_X;
            pos_y_r   <= C_START_Y;
            heading_r <= D_START;
            map_req_r <= 1'b0;
            map_x_r   <= C_ZERO;
            map_y_r   <= C_ZERO;
            moved_r   <= 1'b0;
            blocked_r <= 1'b0;
            busy_r    <= 1'b0;
            tmo_cnt_r <= TO_ZERO;
        end else begin
            pos_x_r   <= pos_x_s;
            pos_y_r   <= pos_y_s;
            heading_r <= heading_s;
            map_req_r <= map_req_s;
            map_x_r   <= map_x_s;
            map_y_r   <= map_y_s;
            moved_r   <= moved_s;
            blocked_r <= blocked_s;
            busy_r    <= (state_s != ST_IDLE);
            tmo_cnt_r <= tmo_cnt_s;
        end
    end

    assign map_req = map_req_r;
    assign map_x   = map_x_r;
    assign map_y   = map_y_r;
    assign pos_x   = pos_x_r;
    assign pos_y   = pos_y_r;
    assign heading = heading_r;
    assign moved   = moved_r;
    assign blocked = blocked_r;
    assign busy    = busy_r;

endmodule
